// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryptor that runs one full round per clock.
// The key schedule comes in expanded form on 'words' and is not registered.
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   plaintext handshake; in_ready is high only in IDLE
//   in_data [0:127]     plaintext, bit 0 is the MSB of byte 0
//   words               round keys; key r is at bits 128r..128r+127
//   out_valid/out_ready ciphertext handshake; out_valid is high only in DONE
//   out_data [0:127]    result register, holds until the next completion
//   busy                high while rounds are being applied
// aes_col is one state column of a round: SubBytes, MixColumns (unless this
// is the last round) and AddRoundKey. ShiftRows is done by the top-level wiring.

module aes_col (
  input  logic [0:31] col_in,   // column bytes already row-shifted, pre-SubBytes
  input  logic [0:31] rk,       // matching round-key word
  input  logic        last,     // final round: skip MixColumns
  output logic [0:31] col_out
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // multiply by x in GF(2^8) with the AES polynomial
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] s, m;

  for (genvar r = 0; r < 4; r++) begin : g_sb
    assign s[r] = SBOX[{col_in[8*r +: 8], 3'b000} +: 8];
  end

  always_comb begin
    m[0] = xt(s[0]) ^ xt(s[1]) ^ s[1] ^ s[2] ^ s[3];
    m[1] = s[0] ^ xt(s[1]) ^ xt(s[2]) ^ s[2] ^ s[3];
    m[2] = s[0] ^ s[1] ^ xt(s[2]) ^ xt(s[3]) ^ s[3];
    m[3] = xt(s[0]) ^ s[0] ^ s[1] ^ s[2] ^ xt(s[3]);
  end

  for (genvar r = 0; r < 4; r++) begin : g_out
    assign col_out[8*r +: 8] = (last ? s[r] : m[r]) ^ rk[8*r +: 8];
  end
endmodule

module aes_cipher_iter #(
  parameter  int NK = 4,
  localparam int NR = NK + 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             in_data,
  input  logic [0:128*(NR+1)-1]    words,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             out_data,
  output logic                     busy
);
  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_cipher_iter: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   rnd_q;
  logic [0:127] st_q, nxt, rkey;
  logic         last;

  assign last = (rnd_q == 4'(NR));
  assign rkey = words[{rnd_q, 7'b0} +: 128];

  // ShiftRows is pure wiring: row r of output column c comes from column c+r
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [0:31] sr;
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[8*r +: 8] = st_q[32*((c+r)%4) + 8*r +: 8];
    end
    aes_col u_col (.col_in(sr), .rk(rkey[32*c +: 32]), .last(last), .col_out(nxt[32*c +: 32]));
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid)  fsm_d = ROUND;
      ROUND:   if (last)      fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default:                fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= IDLE;
      rnd_q    <= '0;
      st_q     <= '0;
      out_data <= '0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        IDLE: if (in_valid) begin
          st_q  <= in_data ^ words[0:127];
          rnd_q <= 4'd1;
        end
        ROUND: begin
          st_q <= nxt;
          if (last) out_data <= nxt;   // counter parks at NR until the next accept
          else      rnd_q    <= rnd_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == ROUND);
  assign out_valid = (fsm_q == DONE);
endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 Parameter NK, default 4, key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256); any other value SHALL cause an elaboration error.
REQ-002 Local constant NR SHALL equal NK+6 (10/12/14 rounds).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  plaintext block offered.
REQ-006 in_ready  output  1  core can accept a block.
REQ-007 in_data  input  [0:127]  plaintext; bit 0 is the MSB of byte 0.
REQ-008 words  input  [0:128*(NR+1)-1]  expanded key schedule; round key r occupies bits 128r to 128r+127, word w0 first.
REQ-009 out_valid  output  1  ciphertext available.
REQ-010 out_ready  input  1  consumer takes ciphertext.
REQ-011 out_data  output  [0:127]  ciphertext result register.
REQ-012 busy  output  1  high in ROUND state.

Function
REQ-013 The FSM SHALL have three states: IDLE, ROUND, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in ROUND; all three SHALL be registered-state decodes.
REQ-015 In IDLE with in_valid=1, the accept edge SHALL load state <= in_data XOR round key 0, set round counter to 1, and enter ROUND.
REQ-016 In IDLE with in_valid=0, the FSM SHALL remain in IDLE, and state and counter SHALL hold.
REQ-017 Each ROUND cycle SHALL apply exactly one round to state, in this order: SubBytes, ShiftRows, MixColumns, AddRoundKey with round key r.
REQ-018 MixColumns SHALL be skipped when r = NR.
REQ-019 When r < NR, the round counter SHALL increment; when r = NR, the result SHALL be written to out_data and the FSM SHALL enter DONE.
REQ-020 out_valid SHALL rise exactly NR cycles after the accept edge: 10 for NK=4, 12 for NK=6, 14 for NK=8.
REQ-021 Round counter SHALL be 4 bits wide and SHALL never exceed NR.
REQ-022 In DONE, out_data SHALL be held stable while out_ready=0.
REQ-023 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge.
REQ-024 Minimum block period with out_ready tied high SHALL be NR+2 cycles.
REQ-025 in_valid outside IDLE SHALL be ignored; the block SHALL not be captured later unless still asserted in IDLE.
REQ-026 out_ready outside DONE SHALL be ignored.
REQ-027 out_data SHALL retain the last result through IDLE and ROUND until the next completion overwrites it.
REQ-028 words is not registered; correct output SHALL be guaranteed only if words is stable from the accept edge to the completion edge.
REQ-029 S-box, ShiftRows and GF(2^8) MixColumns SHALL be combinational and SHALL conform to FIPS-197 encryption.

Reset
REQ-030 rst=1 SHALL immediately force: FSM=IDLE, round counter=0, state=0, out_data=0, in_ready=1, out_valid=0, busy=0.
REQ-031 rst asserted mid-ROUND or in DONE SHALL discard the block in flight; no out_valid SHALL be produced for it.
REQ-032 After rst deasserts, the first rising edge SHALL be able to accept a block.

Verification
REQ-033 NK=4, words = FIPS-197 schedule of key 000102030405060708090a0b0c0d0e0f, in_data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises 10 cycles after accept.
REQ-034 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, in_data 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32.
REQ-035 NK=6, key 000102...1617, in_data 00112233445566778899aabbccddeeff -> out_data dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles; NK=8, key 000102...1e1f, same in_data -> out_data 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data held, in_ready=0, second in_valid not accepted; on out_ready=1 -> IDLE next cycle, then second block accepted.
REQ-037 Reset at round 5 -> all outputs at reset values immediately; out_data=0; no spurious out_valid; the next block encrypts correctly.
REQ-038 Back-to-back streaming, in_valid and out_ready held at 1, 4 blocks -> accepts spaced NR+2 cycles apart, results in order.
